// File: rtl/pmp_access_ctrl.sv
// PMP access controller: round-robin arbitration of fetch/LSU requests, one PMP check per request, held response.
// Optional fault log (fault_log_clr, fault_count, last_fault_addr) is built when PMP_FAULT_LOG_EN is defined.
module pmp_access_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_oper,
  input  logic [1:0]  lsu_size,
  input  logic [1:0]  priv_mode,
  output logic [31:0] pmp_addr,
  output logic [1:0]  pmp_oper,
  output logic [1:0]  pmp_size,
  output logic [1:0]  pmp_priv,
  input  logic [1:0]  pmp_permission,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_src,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause,
  output logic [31:0] rsp_tval
`ifdef PMP_FAULT_LOG_EN
  ,
  input  logic        fault_log_clr,
  output logic [15:0] fault_count,
  output logic [31:0] last_fault_addr
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

  localparam logic [1:0] OPER_READ  = 2'b00;
  localparam logic [1:0] OPER_WRITE = 2'b01;
  localparam logic [1:0] OPER_EXEC  = 2'b10;
  localparam logic [1:0] PERM_OK    = 2'b11;

  state_e      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;  // 1: LSU was granted last
  logic [31:0] addr_q, addr_d;
  logic [1:0]  oper_q, oper_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  priv_q, priv_d;
  logic        src_q, src_d;
  logic [1:0]  perm_q, perm_d;

  logic grant_lsu;
  logic in_flight;
  logic is_resp;
  logic fault;

  assign grant_lsu = lsu_req_valid && (!if_req_valid || !last_lsu_q);
  assign in_flight = (state_q != IDLE);
  assign is_resp   = (state_q == RESP);
  assign fault     = (perm_q != PERM_OK);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    last_lsu_d    = last_lsu_q;
    addr_d        = addr_q;
    oper_d        = oper_q;
    size_d        = size_q;
    priv_d        = priv_q;
    src_d         = src_q;
    perm_d        = perm_q;
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if_req_ready  = if_req_valid && !grant_lsu;
        lsu_req_ready = grant_lsu;
        if (if_req_valid || lsu_req_valid) begin
          state_d    = CHECK;
          last_lsu_d = grant_lsu;
          src_d      = grant_lsu;
          priv_d     = priv_mode;
          if (grant_lsu) begin
            addr_d = lsu_addr;
            oper_d = lsu_oper[1] ? OPER_READ : lsu_oper;
            size_d = lsu_size;
          end else begin
            addr_d = if_addr;
            oper_d = OPER_EXEC;
            size_d = 2'b10;
          end
        end
      end
      CHECK: begin
        perm_d  = pmp_permission;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmp_addr  = in_flight ? addr_q : 32'd0;
  assign pmp_oper  = in_flight ? oper_q : 2'd0;
  assign pmp_size  = in_flight ? size_q : 2'd0;
  assign pmp_priv  = in_flight ? priv_q : 2'd0;

  assign rsp_valid = is_resp;
  assign rsp_src   = is_resp && src_q;
  assign rsp_fault = is_resp && fault;
  assign rsp_tval  = (is_resp && fault) ? addr_q : 32'd0;

  // Cause follows the transaction type: instruction, load or store access fault.
  always_comb begin
    rsp_cause = 4'd0;
    if (is_resp && fault) begin
      if (!src_q)                    rsp_cause = 4'd1;
      else if (oper_q == OPER_WRITE) rsp_cause = 4'd7;
      else                           rsp_cause = 4'd5;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b0;
      addr_q     <= 32'd0;
      oper_q     <= 2'd0;
      size_q     <= 2'd0;
      priv_q     <= 2'd0;
      src_q      <= 1'b0;
      perm_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      addr_q     <= addr_d;
      oper_q     <= oper_d;
      size_q     <= size_d;
      priv_q     <= priv_d;
      src_q      <= src_d;
      perm_q     <= perm_d;
    end
  end

`ifdef PMP_FAULT_LOG_EN
  logic [15:0] fault_count_q, fault_count_d;
  logic [31:0] last_fault_addr_q, last_fault_addr_d;

  always_comb begin
    fault_count_d     = fault_count_q;
    last_fault_addr_d = last_fault_addr_q;
    if (fault_log_clr) begin
      fault_count_d     = 16'd0;
      last_fault_addr_d = 32'd0;
    end else if (is_resp && rsp_ready && fault) begin
      if (fault_count_q != 16'hFFFF) fault_count_d = fault_count_q + 16'd1;
      last_fault_addr_d = addr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_count_q     <= 16'd0;
      last_fault_addr_q <= 32'd0;
    end else begin
      fault_count_q     <= fault_count_d;
      last_fault_addr_q <= last_fault_addr_d;
    end
  end

  assign fault_count     = fault_count_q;
  assign last_fault_addr = last_fault_addr_q;
`endif

endmodule

// File: tb/tb_pmp_access_ctrl.sv
// Self-checking bench for pmp_access_ctrl: directed scenarios plus randomized transactions against a transaction-level model.
module tb_pmp_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_oper, lsu_size, priv_mode;
  logic [31:0] pmp_addr;
  logic [1:0]  pmp_oper, pmp_size, pmp_priv, pmp_permission;
  logic        rsp_valid, rsp_ready, rsp_src, rsp_fault;
  logic [3:0]  rsp_cause;
  logic [31:0] rsp_tval;
`ifdef PMP_FAULT_LOG_EN
  logic        fault_log_clr;
  logic [15:0] fault_count;
  logic [31:0] last_fault_addr;
`endif

  pmp_access_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_oper       (lsu_oper),
    .lsu_size       (lsu_size),
    .priv_mode      (priv_mode),
    .pmp_addr       (pmp_addr),
    .pmp_oper       (pmp_oper),
    .pmp_size       (pmp_size),
    .pmp_priv       (pmp_priv),
    .pmp_permission (pmp_permission),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_src        (rsp_src),
    .rsp_fault      (rsp_fault),
    .rsp_cause      (rsp_cause),
    .rsp_tval       (rsp_tval)
`ifdef PMP_FAULT_LOG_EN
    ,
    .fault_log_clr  (fault_log_clr),
    .fault_count    (fault_count),
    .last_fault_addr(last_fault_addr)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: who was granted last (1 = LSU), and the fault log.
  bit          m_last_lsu = 1'b0;
  int          m_fault_count = 0;
  logic [31:0] m_last_fault_addr = 32'd0;
  bit          clr_on_hs = 1'b0;
  bit          obs_lsu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_requests();
    if_req_valid  = 1'($urandom);
    lsu_req_valid = 1'($urandom);
    if_addr       = $urandom;
    lsu_addr      = $urandom;
    lsu_oper      = 2'($urandom);
    lsu_size      = 2'($urandom);
    priv_mode     = 2'($urandom);
  endtask

  task automatic model_reset();
    m_last_lsu        = 1'b0;
    m_fault_count     = 0;
    m_last_fault_addr = 32'd0;
  endtask

  task automatic check_log();
`ifdef PMP_FAULT_LOG_EN
    check("fault_count", 32'(fault_count), 32'(m_fault_count));
    check("last_fault_addr", last_fault_addr, m_last_fault_addr);
`endif
  endtask

  // One full transaction, entered and left at a negedge with the DUT in IDLE.
  // granted: checker answers 11; otherwise it answers the fault code matching the access type.
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                         input logic [1:0] lop, input logic [1:0] lsz, input logic [1:0] pv,
                         input bit granted, input int hold, input bit rst_in_check);
    bit          e_lsu, e_fault;
    logic [31:0] e_addr;
    logic [1:0]  e_oper, e_size, perm;
    logic [3:0]  e_cause;
    if_req_valid = iv; lsu_req_valid = lv; if_addr = ia; lsu_addr = la;
    lsu_oper = lop; lsu_size = lsz; priv_mode = pv; rsp_ready = 1'b0;
    #1;
    e_lsu = lv && (!iv || !m_last_lsu);
    check("if_req_ready", 32'(if_req_ready), 32'(iv && !e_lsu));
    check("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lsu));
    check("pmp_addr_idle", pmp_addr, 32'd0);
    check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    obs_lsu = lsu_req_ready;
    m_last_lsu = e_lsu;
    e_addr = e_lsu ? la : ia;
    e_oper = !e_lsu ? 2'd2 : (lop >= 2'd2 ? 2'd0 : lop);
    e_size = e_lsu ? lsz : 2'd2;

    @(posedge clock); @(negedge clock);
    check("rsp_valid_check", 32'(rsp_valid), 32'd0);
    check("pmp_addr", pmp_addr, e_addr);
    check("pmp_oper", 32'(pmp_oper), 32'(e_oper));
    check("pmp_size", 32'(pmp_size), 32'(e_size));
    check("pmp_priv", 32'(pmp_priv), 32'(pv));
    perm = granted ? 2'b11 : (!e_lsu ? 2'b10 : (e_oper == 2'd1 ? 2'b01 : 2'b00));
    pmp_permission = perm;
    scramble_requests();
    #1;
    check("readies_check", 32'({if_req_ready, lsu_req_ready}), 32'd0);

    if (rst_in_check) begin
      reset = 1'b1;
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      if_req_valid = 1'b0; lsu_req_valid = 1'b0;
      model_reset();
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_pmp_addr", pmp_addr, 32'd0);
      check("rst_pmp_oper", 32'({pmp_oper, pmp_size, pmp_priv}), 32'd0);
      check("rst_readies", 32'({if_req_ready, lsu_req_ready}), 32'd0);
      check_log();
      return;
    end

    @(posedge clock); @(negedge clock);
    pmp_permission = 2'($urandom);
    e_fault = (perm != 2'b11);
    e_cause = !e_fault ? 4'd0 : (!e_lsu ? 4'd1 : (e_oper == 2'd1 ? 4'd7 : 4'd5));
    for (int i = 0; i <= hold; i++) begin
      rsp_ready = (i == hold);
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_src", 32'(rsp_src), 32'(e_lsu));
      check("rsp_fault", 32'(rsp_fault), 32'(e_fault));
      check("rsp_cause", 32'(rsp_cause), 32'(e_cause));
      check("rsp_tval", rsp_tval, e_fault ? e_addr : 32'd0);
      check("pmp_addr_resp", pmp_addr, e_addr);
      check("readies_resp", 32'({if_req_ready, lsu_req_ready}), 32'd0);
      if (i < hold) begin
        @(posedge clock); @(negedge clock);
        scramble_requests();
      end
    end
`ifdef PMP_FAULT_LOG_EN
    fault_log_clr = clr_on_hs;
`endif
    @(posedge clock); @(negedge clock);
    if (clr_on_hs) begin
      m_fault_count = 0; m_last_fault_addr = 32'd0;
    end else if (e_fault) begin
      if (m_fault_count < 65535) m_fault_count++;
      m_last_fault_addr = e_addr;
    end
`ifdef PMP_FAULT_LOG_EN
    fault_log_clr = 1'b0;
`endif
    rsp_ready = 1'b0;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("pmp_addr_after", pmp_addr, 32'd0);
    check_log();
  endtask

  initial begin
    reset = 1'b1;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0; if_addr = 32'd0; lsu_addr = 32'd0;
    lsu_oper = 2'd0; lsu_size = 2'd0; priv_mode = 2'd0; pmp_permission = 2'd0; rsp_ready = 1'b0;
`ifdef PMP_FAULT_LOG_EN
    fault_log_clr = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_readies", 32'({if_req_ready, lsu_req_ready}), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_pmp", 32'({pmp_oper, pmp_size, pmp_priv}), 32'd0);
    check("reset_rsp_cause", 32'(rsp_cause), 32'd0);
    check_log();

    // Both requesters valid from reset: LSU, fetch, LSU, fetch.
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 2'b00, 2'b10, 2'b00, 1'b1, 0, 1'b0);
      check("rr_order", 32'(obs_lsu), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 2'b00, 2'b00, 2'b00, 1'b1, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h8000_0004, 2'b01, 2'b10, 2'b10, 1'b0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h1234_5678, 2'b11, 2'b01, 2'b01, 1'b0, 5, 1'b0);
    run_txn(1'b1, 1'b0, 32'hDEAD_BEE0, 32'h0, 2'b00, 2'b00, 2'b10, 1'b0, 5, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h4000_0000, 2'b01, 2'b10, 2'b00, 1'b0, 0, 1'b1);

    for (int k = 0; k < 3; k++)
      run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0100 + 32'(k), 2'b00, 2'b00, 2'b01, 1'b0, 0, 1'b0);
`ifdef PMP_FAULT_LOG_EN
    check("log_three", 32'(fault_count), 32'd3);
    fault_log_clr = 1'b1;
    @(posedge clock); @(negedge clock);
    fault_log_clr = 1'b0;
    #1;
    check("log_cleared", 32'(fault_count), 32'd0);
    m_fault_count = 0; m_last_fault_addr = 32'd0;
    clr_on_hs = 1'b1;
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0200, 2'b01, 2'b00, 2'b01, 1'b0, 1, 1'b0);
    clr_on_hs = 1'b0;
`endif

    for (int n = 0; n < 300; n++) begin
      bit iv, lv;
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) begin
        if_req_valid = 1'b0; lsu_req_valid = 1'b0; if_addr = $urandom;
        #1;
        check("idle_readies", 32'({if_req_ready, lsu_req_ready}), 32'd0);
        @(posedge clock); @(negedge clock);
        check("idle_stays", 32'(rsp_valid), 32'd0);
      end else begin
        run_txn(iv, lv, $urandom, $urandom, 2'($urandom), 2'($urandom), 2'($urandom_range(0, 2)),
                1'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmp_access_ctrl.md
PMP_ACCESS_CTRL -- requirements
Module: pmp_access_ctrl

Interface
REQ-001 The block SHALL have ports: clock  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have ports: if_req_valid  in  1  fetch request; if_req_ready  out  1  fetch accept; if_addr  in  32  fetch address (unsigned).
REQ-003 The block SHALL have ports: lsu_req_valid  in  1  load/store request; lsu_req_ready  out  1  LSU accept; lsu_addr  in  32  data address; lsu_oper  in  2  00 read, 01 write; lsu_size  in  2  00 byte, 01 half, 10 word.
REQ-004 The block SHALL have port: priv_mode  in  2  current privilege (00 M, 01 S, 10 U), sampled at accept.
REQ-005 The block SHALL have ports to the PMP checker: pmp_addr  out  32; pmp_oper  out  2; pmp_size  out  2; pmp_priv  out  2; pmp_permission  in  2 (00 read fault, 01 write fault, 10 exec fault, 11 granted).
REQ-006 The block SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_src  out  1  0 fetch, 1 LSU; rsp_fault  out  1; rsp_cause  out  4; rsp_tval  out  32  faulting address.

Function
REQ-007 The FSM SHALL have states IDLE, CHECK, RESP; reset state IDLE.
REQ-008 In IDLE, exactly one of if_req_ready/lsu_req_ready SHALL be high, combinationally, for the selected valid requester; both low if neither valid; both low in CHECK and RESP.
REQ-009 Arbitration SHALL be round-robin: with both valid, grant the source not granted last; single valid is granted regardless; last-grant flag resets to fetch (LSU wins first tie).
REQ-010 On accept (valid and ready), the block SHALL latch addr, oper (fetch uses 10), size (fetch uses 10), priv_mode and source, then go to CHECK.
REQ-011 LSU oper 1x SHALL be coerced to read (00).
REQ-012 pmp_* outputs SHALL drive the latched values in CHECK and RESP and SHALL be zero in IDLE.
REQ-013 In CHECK the block SHALL register pmp_permission and go to RESP next cycle; latency accept-to-rsp_valid is exactly 2 cycles.
REQ-014 rsp_fault SHALL be 1 when the registered permission is not 11.
REQ-015 rsp_cause SHALL be 1 for fetch fault, 5 for read fault, 7 for write fault, 0 when no fault.
REQ-016 rsp_tval SHALL equal the latched address on fault, else 0.
REQ-017 In RESP, rsp_valid SHALL stay high with stable rsp_* until rsp_ready; on rsp_valid and rsp_ready the FSM SHALL return to IDLE next cycle; a new request may be accepted in that IDLE cycle (minimum 3 cycles per request).
REQ-018 Request inputs changing during CHECK/RESP SHALL have no effect on the in-flight transaction.

Reset
REQ-019 Reset SHALL force IDLE, last-grant to fetch, and all outputs to 0 (readies then follow REQ-008 combinationally).
REQ-020 Reset asserted in CHECK or RESP SHALL abandon the transaction; no response is produced.

Configuration
REQ-021 With PMP_FAULT_LOG_EN defined, the block SHALL add ports fault_log_clr  in  1, fault_count  out  16, last_fault_addr  out  32.
REQ-022 With the macro, each RESP handshake with rsp_fault=1 SHALL increment fault_count (saturating at FFFF) and load last_fault_addr; fault_log_clr SHALL zero both, taking priority over a simultaneous fault; reset zeroes both.
REQ-023 Without PMP_FAULT_LOG_EN these ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-024 Fetch if_addr=0x0000_1000, permission=11, rsp_ready=1 -> rsp_valid 2 cycles after accept, src=0, fault=0, cause=0, tval=0.
REQ-025 LSU write lsu_addr=0x8000_0004, permission=01 -> fault=1, cause=7, tval=0x8000_0004, pmp_oper=01.
REQ-026 Both valid continuously for 4 requests from reset -> grant order LSU, fetch, LSU, fetch.
REQ-027 rsp_ready held low 5 cycles in RESP -> rsp_* stable throughout, no new accept; released -> IDLE next cycle.
REQ-028 Reset pulsed in CHECK -> next cycle IDLE, rsp_valid=0, pmp_* zero; with PMP_FAULT_LOG_EN, three read faults then fault_log_clr -> fault_count 3 then 0.
